// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response handshake of the data-memory access sequencer.
// master = control unit, slave = mem_access_ctrl.
interface mem_access_ctrl_if;
  logic        req;
  logic        is_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] mdr;
  logic [1:0]  ld_ct;

  modport master (
    output req, is_store, size, addr, wdata,
    input  ready, done, mdr, ld_ct
  );

  modport slave (
    input  req, is_store, size, addr, wdata,
    output ready, done, mdr, ld_ct
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle sequencer for word/half/byte data-memory loads and stores (sub-word stores via read-modify-write).
// Optional build macro REQ_OVERRUN_EN adds a sticky request-while-busy diagnostic on overrun.
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.slave   cpu,
  output logic [31:0]        mem_addr,
  output logic               mem_wr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [1:0]  size_r;
  logic        store_r;
  logic [31:0] wdata_r;
  logic        ready_r;
  logic        done_r;
  logic [31:0] mdr_r;
  logic [1:0]  ld_ct_r;
  logic [1:0]  size_s;

  // Merge new store data into the old memory word; untouched upper bits survive.
  function automatic logic [31:0] merge_store(input logic [1:0]  sz,
                                              input logic [31:0] old_word,
                                              input logic [31:0] new_data);
    logic [31:0] res;
    case (sz)
      2'b01:   res = {old_word[31:16], new_data[15:0]};
      2'b10:   res = {old_word[31:8], new_data[7:0]};
      default: res = new_data;
    endcase
    return res;
  endfunction

  // Size code 11 is folded to word before it is latched.
  always_comb begin
    if (cpu.size == 2'b11) begin
      size_s = 2'b00;
    end else begin
      size_s = cpu.size;
    end
  end

  assign cpu.ready = ready_r;
  assign cpu.done  = done_r;
  assign cpu.mdr   = mdr_r;
  assign cpu.ld_ct = ld_ct_r;

  // Access sequencer with registered memory and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      size_r    <= 2'b00;
      store_r   <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      mdr_r     <= 32'h0000_0000;
      ld_ct_r   <= 2'b00;
      mem_addr  <= 32'h0000_0000;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu.req) begin
            mem_addr <= cpu.addr;
            size_r   <= size_s;
            store_r  <= cpu.is_store;
            wdata_r  <= cpu.wdata;
            ready_r  <= 1'b0;
            cnt_r    <= 3'd0;
            // Word stores need no old data, so they skip the read phase.
            if (cpu.is_store && (size_s == 2'b00)) begin
              mem_wr    <= 1'b1;
              mem_wdata <= cpu.wdata;
              state_r   <= WR;
            end else begin
              state_r <= RD_WAIT;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt_r == LAT) begin
            mdr_r <= mem_rdata;
            cnt_r <= 3'd0;
            if (store_r) begin
              mem_wdata <= merge_store(size_r, mem_rdata, wdata_r);
              mem_wr    <= 1'b1;
              state_r   <= WR;
            end else begin
              ld_ct_r <= size_r;
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        WR: begin
          mem_wr  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          mem_wr  <= 1'b0;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef REQ_OVERRUN_EN
  logic overrun_r;

  // Sticky flag: a request arrived while the controller was busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (cpu.req && !ready_r) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (MEM_LATENCY=1) with a one-cycle-latency memory model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0000_0000;
  logic        overrun;

  logic        pl_en   = 1'b0;
  logic [31:0] pl_addr = 32'h0000_0000;
  logic [31:0] pl_data = 32'h0000_0000;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  mem_access_ctrl_if cpu_if ();

  mem_access_ctrl #(.MEM_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read (data valid one cycle after address), write on mem_wr, preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[9:2]] <= pl_data;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (cpu_if.done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    cpu_if.req = 1'b1; cpu_if.is_store = st; cpu_if.size = sz;
    cpu_if.addr = a; cpu_if.wdata = d;
    tick();
  endtask

  initial begin
    cpu_if.req = 1'b0; cpu_if.is_store = 1'b0; cpu_if.size = 2'b00;
    cpu_if.addr = 32'h0; cpu_if.wdata = 32'h0;
    reset = 1'b0;
    #12;
    check("rst_ready", {31'd0, cpu_if.ready}, 32'd1);
    check("rst_done", {31'd0, cpu_if.done}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mdr", cpu_if.mdr, 32'h0);
    check("rst_ld_ct", {30'd0, cpu_if.ld_ct}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    // Word load
    preload(32'h40, 32'hDEADBEEF);
    issue(1'b0, 2'b00, 32'h40, 32'h0);
    cpu_if.req = 1'b0;
    check("wl_c1_addr", mem_addr, 32'h40);
    check("wl_c1_wr", {31'd0, mem_wr}, 32'd0);
    check("wl_c1_ready", {31'd0, cpu_if.ready}, 32'd0);
    tick();
    check("wl_c2_addr", mem_addr, 32'h40);
    check("wl_c2_wr", {31'd0, mem_wr}, 32'd0);
    check("wl_c2_done", {31'd0, cpu_if.done}, 32'd0);
    tick();
    check("wl_c3_done", {31'd0, cpu_if.done}, 32'd1);
    check("wl_c3_mdr", cpu_if.mdr, 32'hDEADBEEF);
    check("wl_c3_ld_ct", {30'd0, cpu_if.ld_ct}, 32'd0);
    check("wl_c3_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    check("wl_c4_ready", {31'd0, cpu_if.ready}, 32'd1);
    check("wl_c4_done", {31'd0, cpu_if.done}, 32'd0);

    // Half store read-modify-write
    preload(32'h80, 32'h11223344);
    issue(1'b1, 2'b01, 32'h80, 32'hAAAABBBB);
    cpu_if.req = 1'b0;
    check("hs_c1_wr", {31'd0, mem_wr}, 32'd0);
    check("hs_c1_addr", mem_addr, 32'h80);
    tick();
    check("hs_c2_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    check("hs_c3_wr", {31'd0, mem_wr}, 32'd1);
    check("hs_c3_wdata", mem_wdata, 32'h1122BBBB);
    check("hs_c3_done", {31'd0, cpu_if.done}, 32'd0);
    tick();
    check("hs_c4_done", {31'd0, cpu_if.done}, 32'd1);
    check("hs_c4_wr", {31'd0, mem_wr}, 32'd0);
    check("hs_mem", mem[32], 32'h1122BBBB);
    check("hs_ld_ct_held", {30'd0, cpu_if.ld_ct}, 32'd0);
    tick();

    // Byte store then byte load
    preload(32'h100, 32'hCAFEF00D);
    issue(1'b1, 2'b10, 32'h100, 32'h000000EE);
    cpu_if.req = 1'b0;
    tick();
    tick();
    check("bs_c3_wr", {31'd0, mem_wr}, 32'd1);
    check("bs_c3_wdata", mem_wdata, 32'hCAFEF0EE);
    tick();
    check("bs_c4_done", {31'd0, cpu_if.done}, 32'd1);
    tick();
    issue(1'b0, 2'b10, 32'h100, 32'h0);
    cpu_if.req = 1'b0;
    tick();
    tick();
    check("bl_c3_done", {31'd0, cpu_if.done}, 32'd1);
    check("bl_c3_mdr", cpu_if.mdr, 32'hCAFEF0EE);
    check("bl_c3_ld_ct", {30'd0, cpu_if.ld_ct}, 32'd2);
    tick();

    // Word store: no read phase
    issue(1'b1, 2'b00, 32'h10, 32'h12345678);
    cpu_if.req = 1'b0;
    check("ws_c1_wr", {31'd0, mem_wr}, 32'd1);
    check("ws_c1_wdata", mem_wdata, 32'h12345678);
    check("ws_c1_addr", mem_addr, 32'h10);
    tick();
    check("ws_c2_done", {31'd0, cpu_if.done}, 32'd1);
    check("ws_c2_wr", {31'd0, mem_wr}, 32'd0);
    check("ws_mem", mem[4], 32'h12345678);
    check("ws_ld_ct_held", {30'd0, cpu_if.ld_ct}, 32'd2);
    tick();
    check("ws_c3_ready", {31'd0, cpu_if.ready}, 32'd1);

    // Busy request held high during a load (size 11 folds to word)
    issue(1'b0, 2'b11, 32'h40, 32'h0);
    cpu_if.is_store = 1'b1; cpu_if.size = 2'b00; cpu_if.addr = 32'h80; cpu_if.wdata = 32'h0BADF00D;
    check("bz_c1_ready", {31'd0, cpu_if.ready}, 32'd0);
    tick();
`ifdef REQ_OVERRUN_EN
    check("bz_c2_overrun", {31'd0, overrun}, 32'd1);
`else
    check("bz_c2_overrun", {31'd0, overrun}, 32'd0);
`endif
    tick();
    check("bz_c3_done", {31'd0, cpu_if.done}, 32'd1);
    check("bz_c3_mdr", cpu_if.mdr, 32'hDEADBEEF);
    check("bz_c3_ld_ct", {30'd0, cpu_if.ld_ct}, 32'd0);
    tick();
    cpu_if.req = 1'b0;
    check("bz_c4_done", {31'd0, cpu_if.done}, 32'd0);
    check("bz_c4_ready", {31'd0, cpu_if.ready}, 32'd1);
    tick();
    check("bz_c5_done", {31'd0, cpu_if.done}, 32'd0);
    check("bz_mem80", mem[32], 32'h1122BBBB);
`ifdef REQ_OVERRUN_EN
    check("bz_c5_overrun", {31'd0, overrun}, 32'd1);
`else
    check("bz_c5_overrun", {31'd0, overrun}, 32'd0);
`endif
    check("done_count", done_cnt, 32'd6);

    // Reset abort during WR of a byte store
    issue(1'b1, 2'b10, 32'h100, 32'h00000055);
    cpu_if.req = 1'b0;
    tick();
    tick();
    check("ra_c3_wr", {31'd0, mem_wr}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ra_wr_async", {31'd0, mem_wr}, 32'd0);
    check("ra_done_async", {31'd0, cpu_if.done}, 32'd0);
    tick();
    check("ra_done_held", {31'd0, cpu_if.done}, 32'd0);
    reset = 1'b1;
    tick();
    check("ra_ready", {31'd0, cpu_if.ready}, 32'd1);
    check("ra_mdr", cpu_if.mdr, 32'h0);
    check("ra_ld_ct", {30'd0, cpu_if.ld_ct}, 32'd0);
    check("ra_overrun", {31'd0, overrun}, 32'd0);
    check("ra_mem_kept", mem[64], 32'hCAFEF0EE);
    tick();
    check("ra_done_count", done_cnt, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
